// File: rtl/mem_resp_pkg.sv
// Shared types, widths and the address fault rule for the memory responder.
package mem_resp_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Offset wraps in 32 bits, so addresses below base land far out of range.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || ((off >> 2) >= depth);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator and the memory responder.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [3:0]  wait_cfg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, wait_cfg, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, wait_cfg, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_resp_array.sv
// Word-addressed RAM with per-byte write enables and a registered read port.
import mem_resp_pkg::*;

module mem_resp_array #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clock,
  input  logic                           we,
  input  logic [BE_W-1:0]                be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [WORD_W-1:0]              wdata,
  input  logic                           re,
  output logic [WORD_W-1:0]              rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with optional per-request wait states.
// Build option: define MEM_RESPONDER_WAIT_EN to take the wait count from wait_cfg.
//
// state  | meaning
// S_IDLE | ready for a request
// S_WAIT | counting down wait states for the latched request
// S_RESP | response presented, held until rsp_ready
import mem_resp_pkg::*;

module mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_L = DEPTH_WORDS;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              write_q, fault_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              rd_ok_q, rsp_err_q;

  logic              accept, to_resp;
  logic [3:0]        wait_in;
  logic              req_fault;
  logic [AW-1:0]     req_idx;
  logic              c_write, c_fault;
  logic [AW-1:0]     c_idx;
  logic [WORD_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;
  logic              arr_we, arr_re;
  logic [WORD_W-1:0] arr_rdata;

`ifdef MEM_RESPONDER_WAIT_EN
  assign wait_in = bus.wait_cfg;
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = ^bus.wait_cfg;
  assign wait_in = 4'd0;
`endif

  assign req_fault     = addr_fault(bus.req_addr, BASE_ADDR, DEPTH_L);
  assign req_idx       = AW'((bus.req_addr - BASE_ADDR) >> 2);
  assign bus.req_ready = reset && (state_q == S_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    to_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (wait_in != 4'd0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
            to_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          to_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Zero-wait requests hit the array on the accept edge, before anything is latched.
  always_comb begin
    c_write = write_q;
    c_fault = fault_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    if (state_q == S_IDLE) begin
      c_write = bus.req_write;
      c_fault = req_fault;
      c_idx   = req_idx;
      c_wdata = bus.req_wdata;
      c_be    = bus.req_be;
    end
  end

  assign arr_we = reset && to_resp && c_write && !c_fault;
  assign arr_re = reset && to_resp && !c_write && !c_fault;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rd_ok_q   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) cnt_q <= wait_in;
      else if (state_q == S_WAIT) cnt_q <= cnt_q - 4'd1;
      if (to_resp) begin
        rd_ok_q   <= !c_write && !c_fault;
        rsp_err_q <= c_fault;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      write_q <= bus.req_write;
      fault_q <= req_fault;
      idx_q   <= req_idx;
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
    end
  end

  mem_resp_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clock (clock),
    .we    (arr_we),
    .be    (c_be),
    .addr  (c_idx),
    .wdata (c_wdata),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

  // The read register only moves on a load commit, so it stays stable through RESP.
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rd_ok_q ? arr_rdata : '0;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder against a word-array reference model.
module tb_mem_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_responder_if bus();

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          drv_cyc;
    int          lat;
    bit          seen;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mdl [DEPTH];
  int          vecs = 0;
  int          errs = 0;
  int          cyc  = 0;
  bit          hs_prev = 1'b0;

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic bit mdl_fault(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || (off / 4 >= DEPTH);
  endfunction

  function automatic int exp_lat(input logic [3:0] wc);
`ifdef MEM_RESPONDER_WAIT_EN
    return 1 + int'(wc);
`else
    return 1 + 0 * int'(wc);
`endif
  endfunction

  // Called at posedge+1; returns there with req_ready seen high, or flags a timeout.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL req_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
    end
  endtask

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [3:0] wc, input int hold);
    bit   ok;
    exp_t e;
    int   idx;
    wait_ready(ok);
    if (!ok) return;
    e.err     = mdl_fault(addr);
    e.rdata   = 32'h0;
    e.drv_cyc = cyc;
    e.lat     = exp_lat(wc);
    e.seen    = 1'b0;
    if (!e.err) begin
      idx = int'((addr - BASE) / 4);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        e.rdata = mdl[idx];
      end
    end
    sbq.push_back(e);
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    bus.wait_cfg  = wc;
    bus.req_valid = 1'b1;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (!ok) begin
      vecs++;
      errs++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one (cycle %0d)", cyc);
      sbq.delete();
      return;
    end
    repeat (hold) begin
      @(posedge clock); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    bus.rsp_ready = 1'b0;
  endtask

  // Monitor: compares every presented response cycle against the queue head.
  always @(negedge clock) begin
    if (!reset) begin
      hs_prev = 1'b0;
    end else if (hs_prev) begin
      hs_prev = 1'b0;
      chk("bubble_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("bubble_req_ready", 32'(bus.req_ready), 32'h1);
    end else if (bus.rsp_valid) begin
      if (sbq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_rsp: got rsp_valid 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sbq[0];
        if (!mon_e.seen) begin
          chk("latency", 32'(cyc - mon_e.drv_cyc), 32'(mon_e.lat));
          sbq[0].seen = 1'b1;
        end
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
        chk("req_ready_in_resp", 32'(bus.req_ready), 32'h0);
        if (bus.rsp_ready) begin
          void'(sbq.pop_front());
          hs_prev = 1'b1;
        end
      end
    end else if (sbq.size() > 0 && cyc > sbq[0].drv_cyc) begin
      chk("req_ready_busy", 32'(bus.req_ready), 32'h0);
    end
  end

  initial begin
    bit          ok;
    int          r;
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_be    = 4'h0;
    bus.wait_cfg  = 4'h0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;

    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("idle_req_ready", 32'(bus.req_ready), 32'h1);

    for (int i = 0; i < DEPTH; i++)
      do_req(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 4'($urandom), 0);

    do_req(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 4'h0, 0);
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'h0, 4'h0, 0);
    do_req(1'b1, BASE + 32'h10, 32'h000000AA, 4'b0001, 4'h0, 1);
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'h3, 4'h0, 0);
    do_req(1'b0, BASE + 32'h13, 32'h0, 4'hF, 4'h0, 0);
    do_req(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF, 4'h0, 0);
    do_req(1'b1, BASE + 32'h11, 32'h55555555, 4'hF, 4'h0, 0);
    do_req(1'b1, BASE + 32'(4 * DEPTH), 32'h66666666, 4'hF, 4'h0, 0);
    do_req(1'b1, BASE + 32'h10, 32'h77777777, 4'h0, 4'h0, 0);
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'h0, 4'h3, 0);
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'h0, 4'h3, 5);

`ifdef MEM_RESPONDER_WAIT_EN
    wait_ready(ok);
    bus.req_write = 1'b1;
    bus.req_addr  = BASE + 32'h10;
    bus.req_wdata = 32'h12345678;
    bus.req_be    = 4'hF;
    bus.wait_cfg  = 4'd5;
    bus.req_valid = 1'b1;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    chk("abort_wait_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'h0);
    chk("abort_rsp_err", 32'(bus.rsp_err), 32'h0);
    reset = 1'b1;
    repeat (8) begin
      @(posedge clock); #1;
    end
    chk("abort_idle_req_ready", 32'(bus.req_ready), 32'h1);
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'hF, 4'h0, 0);
`endif

    reset = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    chk("reset2_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset2_rsp_rdata", bus.rsp_rdata, 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'hF, 4'h0, 0);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (r == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      else if (r == 8) a = BASE + 32'(4 * DEPTH + 4 * $urandom_range(0, 8));
      else             a = 32'hFFFF_FFFC;
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    repeat (5) @(posedge clock);
    #1;
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 256, number of 32-bit words in the storage array (power of two, 4..1024).
REQ-002 Parameter BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 req_valid  in  1  initiator presents a request.
REQ-006 req_ready  out  1  responder accepts the request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data.
REQ-010 req_be  in  4  byte enables for stores, bit i gates byte i; ignored on loads.
REQ-011 wait_cfg  in  4  extra wait states per request.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  initiator consumes the response.
REQ-014 rsp_rdata  out  32  load data; 0 for stores and errors.
REQ-015 rsp_err  out  1  request faulted (misaligned or out of range).

Function
REQ-016 FSM states: IDLE, WAIT, RESP; exactly one request outstanding.
REQ-017 req_ready = 1 only in IDLE; a request is accepted when req_valid & req_ready.
REQ-018 On accept, latch write, word index, wdata, be, and wait count; go to WAIT if the count is nonzero, else go to RESP.
REQ-019 WAIT decrements the counter once per cycle; at 1 it goes to RESP.
REQ-020 Fault: req_addr[1:0] != 0, or (req_addr - BASE_ADDR) >> 2 >= DEPTH_WORDS (unsigned, 32-bit wrap); a faulting store writes nothing.
REQ-021 Array access (store commit or load read) occurs on the cycle of the transition into RESP; rsp_rdata and rsp_err are registered on that edge.
REQ-022 Latency: accepted at edge N -> rsp_valid high after edge N+1+W, where W is the latched wait count.
REQ-023 RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_valid & rsp_ready; on that edge it clears rsp_valid and returns to IDLE (one bubble cycle between requests).
REQ-024 A load returns the full word regardless of req_be; a store with be = 4'b0000 is a legal no-op with rsp_err = 0.
REQ-025 A load issued after a store to the same address returns the stored bytes merged with the old unenabled bytes.

Reset
REQ-026 When reset = 0 at an edge: state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0; req_ready = 0 while reset is asserted.
REQ-027 Reset mid-operation aborts the request; a store not yet committed (still in WAIT) is discarded, and no response is issued.
REQ-028 Array contents are not cleared by reset.

Configuration
REQ-029 Macro MEM_RESPONDER_WAIT_EN: when defined, the wait count is latched from wait_cfg (0..15).
REQ-030 When MEM_RESPONDER_WAIT_EN is undefined, wait_cfg is ignored, W = 0 always, and the WAIT state is never entered (fixed latency of 1).

Structure
REQ-031 Package mem_resp_pkg shall hold the FSM state typedef, word width (32), byte-enable width (4), and the fault-check function.
REQ-032 Sub-module mem_resp_array shall be the word-addressed RAM with per-byte write enables and a synchronous read; it is the only storage.

Verification
REQ-033 Store 32'hDEADBEEF, be = 4'hF, to 0x10, then load 0x10 -> rsp_rdata = 32'hDEADBEEF, rsp_err = 0, rsp_valid one cycle after accept (W = 0).
REQ-034 Store 32'h000000AA, be = 4'b0001, over 32'hDEADBEEF at 0x10, then load -> 32'hDEADBEAA.
REQ-035 Load from 0x13 -> rsp_err = 1, rsp_rdata = 0; load from BASE_ADDR + 4*DEPTH_WORDS -> rsp_err = 1; a faulting store leaves the array unchanged.
REQ-036 With MEM_RESPONDER_WAIT_EN defined and wait_cfg = 3: rsp_valid rises 4 cycles after accept, with req_ready = 0 throughout; without the macro it rises 1 cycle after accept.
REQ-037 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready = 0; raise rsp_ready -> IDLE next cycle.
REQ-038 Assert reset during WAIT of a store -> no response, state IDLE; a subsequent load returns the old data.
